// File: rtl/idx_prefix_sequencer.sv
// Sequencer for DD/FD indexed instructions: consumes opcode/operand bytes after a prefix and
// issues one decoded command. Optional macro IDX_PREFIX_CHAIN_EN: a prefix in OPC re-selects the index.
module idx_prefix_sequencer #(
   parameter  int NUM_IDX = 2,
   parameter  int ADDR_W  = 16,
   localparam int SEL_W   = (NUM_IDX > 1) ? $clog2(NUM_IDX) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      prefix_valid,
   input  logic [SEL_W-1:0]          prefix_sel,
   input  logic                      byte_valid,
   input  logic [7:0]                byte_data,
   output logic                      byte_ready,
   input  logic [NUM_IDX*ADDR_W-1:0] idx_value,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic [2:0]                cmd_op,
   output logic [SEL_W-1:0]          cmd_idx,
   output logic [15:0]               cmd_imm,
   output logic [ADDR_W-1:0]         cmd_ea,
   output logic                      illegal
);

   typedef enum logic [2:0] {S_IDLE, S_OPC, S_OPR0, S_OPR1, S_ISSUE} state_t;

   typedef enum logic [2:0] {
      OP_LD_NN  = 3'd0,
      OP_LD_IND = 3'd1,
      OP_ST_IND = 3'd2,
      OP_INC    = 3'd3,
      OP_DEC    = 3'd4,
      OP_ST_N   = 3'd5
   } op_t;

   state_t             state_q, state_d;
   op_t                op_q, op_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [15:0]        imm_q, imm_d;
   logic [ADDR_W-1:0]  ea_q, ea_d;
   logic               illegal_q, illegal_d;

   logic               xfer;
   logic [ADDR_W-1:0]  idx_sel;
   logic [ADDR_W-1:0]  d_ext;

   // Out-of-range selectors fall back to index 0.
   function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
      return (int'(s) >= NUM_IDX) ? '0 : s;
   endfunction

   assign byte_ready = (state_q == S_OPC) || (state_q == S_OPR0) || (state_q == S_OPR1);
   assign cmd_valid  = (state_q == S_ISSUE);
   assign xfer       = byte_valid && byte_ready;
   assign idx_sel    = idx_value[int'(sel_q)*ADDR_W +: ADDR_W];
   assign d_ext      = {{(ADDR_W-8){byte_data[7]}}, byte_data};

   assign cmd_op  = op_q;
   assign cmd_idx = sel_q;
   assign cmd_imm = imm_q;
   assign cmd_ea  = ea_q;
   assign illegal = illegal_q;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path leaves one
      // unassigned and no latch is inferred.
      state_d   = state_q;
      op_d      = op_q;
      sel_d     = sel_q;
      imm_d     = imm_q;
      ea_d      = ea_q;
      illegal_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (prefix_valid) begin
               sel_d   = clamp_sel(prefix_sel);
               op_d    = OP_LD_NN;
               imm_d   = '0;
               ea_d    = '0;
               state_d = S_OPC;
            end
         end
         S_OPC: begin
`ifdef IDX_PREFIX_CHAIN_EN
            if (prefix_valid) sel_d = clamp_sel(prefix_sel);
`endif
            if (xfer) begin
               state_d = S_OPR0;
               case (byte_data)
                  8'h21:   op_d = OP_LD_NN;
                  8'h2A:   op_d = OP_LD_IND;
                  8'h22:   op_d = OP_ST_IND;
                  8'h34:   op_d = OP_INC;
                  8'h35:   op_d = OP_DEC;
                  8'h36:   op_d = OP_ST_N;
                  default: begin
                     illegal_d = 1'b1;
                     state_d   = S_IDLE;
                  end
               endcase
            end
         end
         S_OPR0: begin
            if (xfer) begin
               if (op_q == OP_INC || op_q == OP_DEC) begin
                  ea_d    = idx_sel + d_ext;
                  state_d = S_ISSUE;
               end else if (op_q == OP_ST_N) begin
                  ea_d    = idx_sel + d_ext;
                  state_d = S_OPR1;
               end else begin
                  imm_d[7:0] = byte_data;
                  state_d    = S_OPR1;
               end
            end
         end
         S_OPR1: begin
            if (xfer) begin
               if (op_q == OP_ST_N) imm_d = {8'h00, byte_data};
               else                 imm_d[15:8] = byte_data;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (cmd_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples the
      // pre-edge values regardless of statement order.
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= OP_LD_NN;
         sel_q     <= '0;
         imm_q     <= '0;
         ea_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         sel_q     <= sel_d;
         imm_q     <= imm_d;
         ea_q      <= ea_d;
         illegal_q <= illegal_d;
      end
   end

endmodule

// File: tb/tb_idx_prefix_sequencer.sv
// Scoreboard bench for idx_prefix_sequencer: directed cases plus randomized instructions,
// expectations from an opcode-level reference model.
module tb_idx_prefix_sequencer;

   localparam int NUM_IDX = 2;
   localparam int ADDR_W  = 16;
   localparam int SEL_W   = 1;

   typedef struct packed {
      logic              ill;
      logic [2:0]        op;
      logic [SEL_W-1:0]  idx;
      logic [15:0]       imm;
      logic [ADDR_W-1:0] ea;
   } exp_t;

   logic                      clk = 1'b0;
   logic                      reset = 1'b1;
   logic                      prefix_valid = 1'b0;
   logic [SEL_W-1:0]          prefix_sel = '0;
   logic                      byte_valid = 1'b0;
   logic [7:0]                byte_data = '0;
   logic                      byte_ready;
   logic [NUM_IDX*ADDR_W-1:0] idx_value = '0;
   logic                      cmd_valid;
   logic                      cmd_ready = 1'b0;
   logic [2:0]                cmd_op;
   logic [SEL_W-1:0]          cmd_idx;
   logic [15:0]               cmd_imm;
   logic [ADDR_W-1:0]         cmd_ea;
   logic                      illegal;

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];
   bit   rand_rdy = 1'b0;
   logic rdy_force = 1'b1;

   idx_prefix_sequencer #(.NUM_IDX(NUM_IDX), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .prefix_valid (prefix_valid),
      .prefix_sel   (prefix_sel),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_ready   (byte_ready),
      .idx_value    (idx_value),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_idx      (cmd_idx),
      .cmd_imm      (cmd_imm),
      .cmd_ea       (cmd_ea),
      .illegal      (illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=missing required=present", name);
   endtask

   // Reference model: decodes a whole instruction from its bytes in one step.
   function automatic bit is_legal(input logic [7:0] opc);
      return opc inside {8'h21, 8'h2A, 8'h22, 8'h34, 8'h35, 8'h36};
   endfunction

   function automatic int num_bytes(input logic [7:0] opc);
      if (opc inside {8'h21, 8'h2A, 8'h22, 8'h36}) return 3;
      if (opc inside {8'h34, 8'h35}) return 2;
      return 1;
   endfunction

   function automatic exp_t model(input logic [7:0] opc, input logic [7:0] b1, input logic [7:0] b2,
                                  input int sel, input logic [NUM_IDX*ADDR_W-1:0] idxv);
      exp_t e;
      int   base, disp, addr;
      base = int'((idxv >> (sel * ADDR_W)) & 32'hFFFF);
      disp = (int'(b1) >= 128) ? int'(b1) - 256 : int'(b1);
      addr = (base + disp + 65536) % 65536;
      e     = '0;
      e.idx = SEL_W'(sel);
      case (opc)
         8'h21: begin e.op = 3'd0; e.imm = 16'(int'(b2) * 256 + int'(b1)); end
         8'h2A: begin e.op = 3'd1; e.imm = 16'(int'(b2) * 256 + int'(b1)); end
         8'h22: begin e.op = 3'd2; e.imm = 16'(int'(b2) * 256 + int'(b1)); end
         8'h34: begin e.op = 3'd3; e.ea = 16'(addr); end
         8'h35: begin e.op = 3'd4; e.ea = 16'(addr); end
         8'h36: begin e.op = 3'd5; e.ea = 16'(addr); e.imm = 16'(b2); end
         default: e = '{ill: 1'b1, default: '0};
      endcase
      return e;
   endfunction

   always @(posedge clk) begin
      #1;
      cmd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
   end

   // Monitor: every held command must match the scoreboard head; pop on handshake.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset) begin
         if (illegal) begin
            if (sb_q.size() == 0) fail_now("illegal_unexpected");
            else begin
               e = sb_q.pop_front();
               check("illegal_expected", 64'(1'b1), 64'(e.ill));
            end
         end
         if (cmd_valid) begin
            if (sb_q.size() == 0) fail_now("cmd_unexpected");
            else begin
               e = sb_q[0];
               check("cmd_fields", 64'({1'b0, cmd_op, cmd_idx, cmd_imm, cmd_ea}), 64'(e));
               if (cmd_ready) void'(sb_q.pop_front());
            end
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!byte_ready && !cmd_valid) return;
      end
      fail_now("idle_timeout");
   endtask

   task automatic prefix(input int sel);
      @(posedge clk); #1;
      prefix_valid = 1'b1;
      prefix_sel   = SEL_W'(sel);
      @(posedge clk); #1;
      prefix_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic rdy;
      repeat ($urandom_range(0, 2)) begin
         byte_valid = 1'b0;
         byte_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         rdy = byte_ready;
         @(posedge clk); #1;
         if (rdy) begin
            byte_valid = 1'b0;
            return;
         end
      end
      byte_valid = 1'b0;
      fail_now("byte_timeout");
   endtask

   // Sends one instruction after the prefix; idx_value is scrambled once d has been taken.
   task automatic do_body(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [NUM_IDX*ADDR_W-1:0] idxv, input int exp_sel);
      exp_t e;
      int   n;
      idx_value = idxv;
      e = model(b0, b1, b2, exp_sel, idxv);
      sb_q.push_back(e);
      n = num_bytes(b0);
      send_byte(b0);
      if (n > 1) begin
         send_byte(b1);
         if (b0 inside {8'h34, 8'h35, 8'h36}) idx_value = 32'($urandom);
      end
      if (n > 2) send_byte(b2);
      @(negedge clk);
      if (e.ill) check("illegal_latency", 64'(illegal), 64'(1'b1));
      else       check("cmd_latency", 64'(cmd_valid), 64'(1'b1));
   endtask

   initial begin
      logic [7:0] tbl [6];
      logic [7:0] opc;
      int         sel, cnt, exp_sel;
      tbl = '{8'h21, 8'h2A, 8'h22, 8'h34, 8'h35, 8'h36};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_handshake", 64'({byte_ready, cmd_valid, illegal}), 64'(0));
      check("reset_cmd_fields", 64'({cmd_op, cmd_idx, cmd_imm, cmd_ea}), 64'(0));
      @(posedge clk); #1;
      reset = 1'b0;

      // LD IY,nn with cmd_ready held high
      rand_rdy = 1'b0; rdy_force = 1'b1;
      wait_idle(); prefix(1);
      do_body(8'h21, 8'h34, 8'h12, {16'hAAAA, 16'h5555}, 1);

      // INC (IX+d) with negative displacement, then wrap below zero
      wait_idle(); prefix(0);
      do_body(8'h34, 8'hFE, 8'h00, {16'h1111, 16'h0005}, 0);
      wait_idle(); prefix(0);
      do_body(8'h34, 8'h80, 8'h00, {16'h1111, 16'h0000}, 0);

      // LD (IX+d),n with five cycles of backpressure
      rdy_force = 1'b0;
      wait_idle(); prefix(0);
      do_body(8'h36, 8'h01, 8'hAA, {16'h2222, 16'hFFFF}, 0);
      cnt = 0;
      for (int k = 0; k < 20 && cmd_valid; k++) begin
         cnt++;
         check("bp_byte_ready", 64'(byte_ready), 64'(0));
         if (cnt == 5) rdy_force = 1'b1;
         @(negedge clk);
      end
      check("bp_hold_cycles", 64'(cnt), 64'(6));

      // Illegal opcode, then LD (nn),IX
      wait_idle(); prefix(0);
      do_body(8'h00, 8'h00, 8'h00, {16'h0, 16'h0}, 0);
      wait_idle(); prefix(0);
      do_body(8'h22, 8'h00, 8'h80, {16'h0, 16'h0}, 0);

      // Reset in the middle of LD IX,(nn)
      wait_idle(); prefix(0);
      send_byte(8'h2A);
      send_byte(8'h11);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_outputs", 64'({byte_ready, cmd_valid, illegal}), 64'(0));
      prefix(1);
      do_body(8'h2A, 8'h11, 8'h22, {16'h3333, 16'h4444}, 1);

      // Back-to-back prefixes: the later one wins only with chaining enabled
`ifdef IDX_PREFIX_CHAIN_EN
      exp_sel = 1;
`else
      exp_sel = 0;
`endif
      wait_idle(); prefix(0); prefix(1);
      do_body(8'h21, 8'h00, 8'h01, {16'h5555, 16'h6666}, exp_sel);

      // Randomized instructions with random backpressure and byte stalls
      rand_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, NUM_IDX - 1);
         if ($urandom_range(0, 6) < 6) opc = tbl[$urandom_range(0, 5)];
         else begin
            opc = 8'($urandom);
            while (is_legal(opc)) opc = 8'($urandom);
         end
         wait_idle(); prefix(sel);
         do_body(opc, 8'($urandom), 8'($urandom), 32'($urandom), sel);
      end

      wait_idle();
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/idx_prefix_sequencer.md
Name: idx_prefix_sequencer

Overview:
- Sequential successor to the combinational DD/FD opcode decoder.
- After a prefix strobe selects an index register, it consumes the opcode byte and operand bytes over a valid/ready byte stream.
- It decodes the six indexed ops, assembles immediates, and computes the effective address index+d.
- It issues a single command to the execute stage over a valid/ready handshake.

Parameters:
- NUM_IDX, 2, number of index registers; prefix_sel selects one (0=IX, 1=IY, 2+ for extensions).
- ADDR_W, 16, width of index registers and of the effective address.
- SEL_W, $clog2(NUM_IDX) (min 1), width of the index selector.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- prefix_valid  in  1  prefix byte seen; starts a sequence.
- prefix_sel  in  SEL_W  index register chosen by the prefix.
- byte_valid  in  1  instruction-stream byte available.
- byte_data  in  8  instruction-stream byte.
- byte_ready  out  1  block accepts byte_data this cycle.
- idx_value  in  NUM_IDX*ADDR_W  flattened index register values; slot k = bits [k*ADDR_W +: ADDR_W].
- cmd_valid  out  1  command held.
- cmd_ready  in  1  execute stage accepts.
- cmd_op  out  3  0=LD I,nn; 1=LD I,(nn); 2=LD (nn),I; 3=INC (I+d); 4=DEC (I+d); 5=LD (I+d),n.
- cmd_idx  out  SEL_W  latched prefix_sel.
- cmd_imm  out  16  nn (little-endian) or n in [7:0] with [15:8]=0; 0 for INC/DEC.
- cmd_ea  out  ADDR_W  index+sext(d) for ops 3-5; 0 otherwise.
- illegal  out  1  one-cycle pulse on an undecoded opcode.

Behaviour:
- State machine: IDLE, OPC, OPR0, OPR1, ISSUE. Reset forces IDLE.
- Reset values: all outputs 0 (byte_ready=0, cmd_valid=0, illegal=0); cmd_* registers 0.
- byte_ready=1 only in OPC, OPR0, OPR1. A byte transfers on byte_valid&byte_ready.
- IDLE:
  - prefix_valid latches prefix_sel and moves to OPC.
  - Bytes are not consumed in IDLE.
  - prefix_sel >= NUM_IDX is treated as 0.
- OPC, on transfer:
  - 0x21/0x2A/0x22 -> op 0/1/2, go to OPR0.
  - 0x34/0x35 -> op 3/4, go to OPR0 (d).
  - 0x36 -> op 5, go to OPR0 (d).
  - Any other byte -> illegal=1 next cycle, return to IDLE, no command issued.
- OPR0, on transfer:
  - Ops 0-2: byte is nn low, go to OPR1.
  - Ops 3-4: byte is d; cmd_ea = idx_value[sel] + sign-extended d, modulo 2^ADDR_W; go to ISSUE.
  - Op 5: byte is d, compute cmd_ea the same way, go to OPR1.
- OPR1, on transfer:
  - Ops 0-2: byte is nn high, go to ISSUE.
  - Op 5: byte is n, go to ISSUE.
- Index sampling: idx_value is sampled in the cycle the d byte transfers, not at prefix time.
- ISSUE:
  - cmd_valid=1 and all cmd_* fields stable until cmd_valid&cmd_ready.
  - On that handshake, the next cycle is IDLE with cmd_valid=0.
  - No byte is accepted while in ISSUE.
- Latency: the command is valid the cycle after the last operand byte transfers. Minimum per instruction: prefix + 2 byte cycles + 1 = 4 cycles for INC/DEC.
- prefix_valid while not in IDLE: ignored, unless the optional feature is enabled.
- Stalls: byte_valid=0 holds state indefinitely.
- Address wrap: 0xFFFF + 0x01 -> 0x0000; 0x0000 + 0x80 (-128) -> 0xFF80.
- Reset mid-sequence: the partial instruction is discarded, IDLE the next cycle, and no cmd_valid or illegal pulse is produced.

Optional Feature:
- IDX_PREFIX_CHAIN_EN defined:
  - prefix_valid in OPC re-latches prefix_sel (last prefix wins, Z80 DD FD semantics) and stays in OPC.
  - If prefix_valid and a byte transfer coincide in OPC, the byte is decoded under the new prefix_sel.
- Undefined: prefix_valid outside IDLE is ignored entirely.

Test Plan:
- LD IY,nn: prefix sel=1, bytes 21,34,12, cmd_ready=1 -> cmd_valid one cycle after the 0x12 transfer, op=0, idx=1, imm=0x1234, ea=0.
- INC (IX+d) with negative d: IX=0x0005, prefix sel=0, bytes 34,FE -> op=3, ea=0x0003, imm=0; with IX=0x0000 and d=0x80 -> ea=0xFF80.
- LD (IX+d),n with backpressure: IX=0xFFFF, bytes 36,01,AA, cmd_ready low for 5 cycles -> ea=0x0000, imm=0x00AA; cmd_valid held 6 cycles, fields stable, byte_ready=0 throughout.
- Illegal opcode: prefix, byte 0x00 -> illegal=1 for exactly one cycle, no cmd_valid, back in IDLE; a following LD (nn),IX with bytes 22,00,80 -> op=2, imm=0x8000.
- Reset mid-sequence: prefix, bytes 2A,11, then reset for 1 cycle -> byte_ready=0, cmd_valid=0; a fresh sequence decodes correctly.
- Prefix chaining (IDX_PREFIX_CHAIN_EN): prefix sel=0, prefix sel=1, bytes 21,00,01 -> idx=1, imm=0x0100. Without the macro -> idx=0.
